// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM pipeline stage of the 16-bit CPU. Issues data-memory and
//             bus accesses over valid/ack handshakes, stalls upstream while an
//             access is outstanding, aborts hung accesses after TIMEOUT wait
//             cycles and drives the MEM/WB register.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] iAluOut,
  input  logic [15:0] iData2,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iBusWrite,
  input  logic        iAlutoReg,
  input  logic        iMemtoReg,
  input  logic        iBustoReg,
  input  logic [3:0]  iDest,
  input  logic        iHalt,
  output logic        oStall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        oWbEn,
  output logic [15:0] oWbData,
  output logic [3:0]  oDest,
  output logic        oHalt,
  output logic        oErr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    BUS_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_we;
  logic [3:0]  lat_dest;
  logic        lat_alu2reg;
  logic        lat_mem2reg;
  logic        lat_bus2reg;

  logic        sel_mem;
  logic        sel_bus;
  logic        sel_we;
  logic        idle_act;
  logic        new_mem;
  logic        new_bus;
  logic        in_mem_wait;
  logic        in_bus_wait;
  logic        in_wait;
  logic        ack_now;
  logic        timeout_hit;
  logic        new_wb_en;
  logic [15:0] new_wb_data;
  logic        lat_wb_en;
  logic [15:0] lat_wb_data;

  // Request priority decode and handshake status for the current cycle
  always_comb begin
    sel_mem     = iMemWrite | iMemRead;
    sel_bus     = !sel_mem && (iBusWrite || iBustoReg);
    sel_we      = sel_mem ? iMemWrite : iBusWrite;
    // reset gates the IDLE launch path so req drops the moment rst_n falls
    idle_act    = rst_n && (state == IDLE);
    new_mem     = idle_act & sel_mem;
    new_bus     = idle_act & sel_bus;
    in_mem_wait = (state == MEM_WAIT);
    in_bus_wait = (state == BUS_WAIT);
    in_wait     = in_mem_wait | in_bus_wait;
    ack_now     = ((new_mem | in_mem_wait) & dmem_ack) |
                  ((new_bus | in_bus_wait) & bus_ack);
    timeout_hit = in_wait && !ack_now &&
                  (({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT));
    // the abort cycle releases upstream just like a completion
    oStall      = ((new_mem | new_bus) & !ack_now) |
                  (in_wait & !ack_now & !timeout_hit);
  end

  // Memory and bus request outputs: live inputs on launch, latched copy while waiting
  always_comb begin
    dmem_req   = new_mem | in_mem_wait;
    dmem_we    = new_mem ? sel_we  : (in_mem_wait & lat_we);
    dmem_addr  = new_mem ? iAluOut : (in_mem_wait ? lat_addr  : 16'h0000);
    dmem_wdata = new_mem ? iData2  : (in_mem_wait ? lat_wdata : 16'h0000);
    bus_req    = new_bus | in_bus_wait;
    bus_we     = new_bus ? sel_we  : (in_bus_wait & lat_we);
    bus_addr   = new_bus ? iAluOut : (in_bus_wait ? lat_addr  : 16'h0000);
    bus_wdata  = new_bus ? iData2  : (in_bus_wait ? lat_wdata : 16'h0000);
  end

  // Writeback value selection for live and latched operations
  always_comb begin
    new_wb_en   = iAlutoReg | iMemtoReg | iBustoReg;
    new_wb_data = iMemtoReg ? dmem_rdata : (iBustoReg ? bus_rdata : iAluOut);
    lat_wb_en   = lat_alu2reg | lat_mem2reg | lat_bus2reg;
    lat_wb_data = lat_mem2reg ? dmem_rdata : (lat_bus2reg ? bus_rdata : lat_addr);
  end

  // Stage FSM, wait counter, access latches and MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      lat_addr    <= 16'h0000;
      lat_wdata   <= 16'h0000;
      lat_we      <= 1'b0;
      lat_dest    <= 4'd0;
      lat_alu2reg <= 1'b0;
      lat_mem2reg <= 1'b0;
      lat_bus2reg <= 1'b0;
      oWbEn       <= 1'b0;
      oWbData     <= 16'h0000;
      oDest       <= 4'd0;
      oHalt       <= 1'b0;
      oErr        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_mem || sel_bus) begin
            lat_addr    <= iAluOut;
            lat_wdata   <= iData2;
            lat_we      <= sel_we;
            lat_dest    <= iDest;
            lat_alu2reg <= iAlutoReg;
            lat_mem2reg <= iMemtoReg;
            lat_bus2reg <= iBustoReg;
            wait_cnt    <= 8'd0;
            if (ack_now) begin
              oWbEn   <= new_wb_en;
              oWbData <= new_wb_data;
              oDest   <= iDest;
            end else begin
              oWbEn <= 1'b0;
              state <= sel_mem ? MEM_WAIT : BUS_WAIT;
            end
          end else begin
            oWbEn   <= new_wb_en;
            oWbData <= new_wb_data;
            oDest   <= iDest;
            if (iHalt) begin
              oHalt <= 1'b1;
              state <= HALTED;
            end
          end
        end
        MEM_WAIT, BUS_WAIT: begin
          if (ack_now) begin
            oWbEn   <= lat_wb_en;
            oWbData <= lat_wb_data;
            oDest   <= lat_dest;
            state   <= IDLE;
          end else if (timeout_hit) begin
            oWbEn <= 1'b0;
            oErr  <= 1'b1;
            state <= IDLE;
          end else begin
            oWbEn    <= 1'b0;
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          oWbEn <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage. A driver issues directed and
//             random operations, acting as the memory/bus responder; expected
//             writebacks go to a queue popped by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] iAluOut, iData2;
  logic        iMemRead, iMemWrite, iBusWrite, iAlutoReg, iMemtoReg, iBustoReg;
  logic [3:0]  iDest;
  logic        iHalt;
  logic        oStall;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        oWbEn;
  logic [15:0] oWbData;
  logic [3:0]  oDest;
  logic        oHalt, oErr;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .iAluOut(iAluOut), .iData2(iData2),
    .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iBusWrite(iBusWrite),
    .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
    .iDest(iDest), .iHalt(iHalt), .oStall(oStall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .oWbEn(oWbEn), .oWbData(oWbData), .oDest(oDest),
    .oHalt(oHalt), .oErr(oErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dest;
  } wb_t;

  wb_t         exp_q[$];
  logic [15:0] refmem [bit [15:0]];
  logic        model_err;
  bit          mon_en;

  // Memory contents: written locations from the model, others a fixed pattern
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (refmem.exists(a)) return refmem[a];
    return a ^ 16'h5A5A;
  endfunction

  // Monitor: every retirement must match the oldest expected writeback
  always @(posedge clk) begin
    wb_t e;
    #1;
    if (mon_en && oWbEn) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_data", oWbData, e.data);
        chk("wb_dest", oDest, e.dest);
      end
    end
  end

  task automatic clear_inputs();
    iMemRead = 0; iMemWrite = 0; iBusWrite = 0;
    iAlutoReg = 0; iMemtoReg = 0; iBustoReg = 0;
    iHalt = 0; dmem_ack = 0; bus_ack = 0;
  endtask

  // Issue one operation at a negedge; ack arrives d cycles after launch
  task automatic issue(input logic mw, input logic mr, input logic bw,
                       input logic a2r, input logic m2r, input logic b2r,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [3:0] dest, input int d, input logic halt);
    int          kind;
    logic        we;
    int          cyc;
    bit          aborted;
    logic [15:0] rd;
    kind = 0; we = 0;
    if (mw)       begin kind = 1; we = 1; end
    else if (mr)  begin kind = 1; we = 0; end
    else if (bw)  begin kind = 2; we = 1; end
    else if (b2r) begin kind = 2; we = 0; end
    iMemWrite = mw; iMemRead = mr; iBusWrite = bw;
    iAlutoReg = a2r; iMemtoReg = m2r; iBustoReg = b2r;
    iAluOut = addr; iData2 = wdata; iDest = dest;
    iHalt = halt && (kind != 0);
    rd = mem_rd(addr);
    dmem_rdata = rd;
    bus_rdata = ~addr;
    cyc = 0; aborted = 0;
    while (1) begin
      dmem_ack = (kind == 1) && (cyc == d);
      bus_ack  = (kind == 2) && (cyc == d);
      #1;
      if (kind == 0) begin
        chk("stall_nonaccess", oStall, 32'd0);
        break;
      end
      chk("dmem_req", dmem_req, kind == 1);
      chk("bus_req", bus_req, kind == 2);
      if (kind == 1) begin
        chk("dmem_addr", dmem_addr, addr);
        chk("dmem_we", dmem_we, we);
        if (we) chk("dmem_wdata", dmem_wdata, wdata);
      end else begin
        chk("bus_addr", bus_addr, addr);
        chk("bus_we", bus_we, we);
        if (we) chk("bus_wdata", bus_wdata, wdata);
      end
      chk("stall", oStall, (cyc != d) && (cyc < TO));
      if (cyc == d) break;
      if (cyc >= TO) begin aborted = 1; break; end
      @(negedge clk);
      cyc++;
    end
    if (aborted) begin
      model_err = 1;
    end else begin
      if (a2r || m2r || b2r)
        exp_q.push_back({(m2r ? rd : (b2r ? ~addr : addr)), dest});
      if (kind == 1 && we) refmem[addr] = wdata;
    end
    @(negedge clk);
    chk("err", oErr, model_err);
    clear_inputs();
  endtask

  initial begin
    logic mw, mr, bw, a2r, m2r, b2r;
    clear_inputs();
    iAluOut = 0; iData2 = 0; iDest = 0;
    dmem_rdata = 0; bus_rdata = 0;
    rst_n = 0; mon_en = 0; model_err = 0;
    refmem[16'h0040] = 16'hBEEF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", oStall, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_wben", oWbEn, 0);
    chk("rst_wbdata", oWbData, 0);
    chk("rst_dest", oDest, 0);
    chk("rst_halt", oHalt, 0);
    chk("rst_err", oErr, 0);
    rst_n = 1; mon_en = 1;
    @(negedge clk);

    issue(0, 0, 0, 1, 0, 0, 16'h1234, 16'h0000, 4'd3, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 16'h0010, 16'hA5A5, 4'd5, 0, 0);
    issue(0, 1, 0, 0, 1, 0, 16'h0040, 16'h0000, 4'd7, 3, 0);
    issue(0, 0, 0, 0, 0, 1, 16'h0100, 16'h0000, 4'd9, 1000, 0);
    issue(0, 0, 0, 1, 0, 0, 16'h4321, 16'h0000, 4'd2, 0, 0);
    issue(0, 1, 0, 0, 1, 0, 16'h0010, 16'h0000, 4'd1, 1, 0);

    repeat (200) begin
      mw  = ($urandom_range(0, 4) == 0);
      mr  = ($urandom_range(0, 2) == 0);
      bw  = ($urandom_range(0, 4) == 0);
      b2r = ($urandom_range(0, 4) == 0);
      m2r = mr && ($urandom_range(0, 3) != 0);
      a2r = ($urandom_range(0, 1) == 0);
      issue(mw, mr, bw, a2r, m2r, b2r,
            16'(($urandom_range(0, 7)) << 1), 16'($urandom),
            4'($urandom), int'($urandom_range(0, TO + 1)),
            ($urandom_range(0, 3) == 0));
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    iHalt = 1;
    @(negedge clk);
    iHalt = 0;
    chk("halt_set", oHalt, 1);
    iMemRead = 1; iMemtoReg = 1; iAluOut = 16'h0040;
    repeat (3) begin
      #1;
      chk("halted_dmem_req", dmem_req, 0);
      chk("halted_stall", oStall, 0);
      @(negedge clk);
      chk("halted_wben", oWbEn, 0);
    end
    rst_n = 0;
    #1;
    chk("rst_clears_halt", oHalt, 0);
    chk("rst_clears_err", oErr, 0);
    model_err = 0;
    exp_q.delete();
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    iMemRead = 1; iMemtoReg = 1; iAluOut = 16'h0040; iDest = 4'd6;
    repeat (2) @(negedge clk);
    #1;
    chk("wait_dmem_req", dmem_req, 1);
    chk("wait_stall", oStall, 1);
    rst_n = 0;
    #1;
    chk("midrst_dmem_req", dmem_req, 0);
    chk("midrst_stall", oStall, 0);
    chk("midrst_wben", oWbEn, 0);
    chk("midrst_wbdata", oWbData, 0);
    chk("midrst_dest", oDest, 0);
    chk("midrst_err", oErr, 0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_wben", oWbEn, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
